// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged release of per-channel active-low resets
module reset_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_rstn,
    input  logic              sw_rst,
    output logic [NUM_CH-1:0] ch_rstn,
    output logic              done
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH + 1) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [NUM_CH-1:0]      r_ch_rstn;
    logic [NUM_CH-1:0]      w_ch_nxt;
    logic [NUM_CH:0]        w_ch_shift;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_ext_sync;
    logic                   w_req;

    assign w_ext_sync = r_sync[SYNC_STAGES-1];
    assign w_req      = ~w_ext_sync | sw_rst;
    // Shifting a 1 in at the bottom releases the next channel and keeps the thermometer shape.
    assign w_ch_shift = {r_ch_rstn, 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_ch_nxt    = r_ch_rstn;
        w_done_nxt  = r_done;
        case (r_state)
            HOLD: begin
                w_ch_nxt   = '0;
                w_done_nxt = 1'b0;
                w_idx_nxt  = '0;
                if (w_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_ch_nxt[0] = 1'b1;
                    if (NUM_CH == 1) begin
                        w_state_nxt = RUN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = STEP;
                        w_idx_nxt   = IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            STEP: begin
                if (w_req) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ch_nxt    = '0;
                    w_done_nxt  = 1'b0;
                end else if (r_cnt == STEP_LAST) begin
                    w_cnt_nxt = '0;
                    w_ch_nxt  = w_ch_shift[NUM_CH-1:0];
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = RUN;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (w_req) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ch_nxt    = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_ch_nxt    = '0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_ch_rstn <= '0;
            r_done    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], ext_rstn};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_ch_rstn <= w_ch_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign ch_rstn = r_ch_rstn;
    assign done    = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst, ext_rstn, sw_rst;
    logic [2:0] ch_rstn;
    logic       done;
    logic       rst1, ext_rstn1, sw_rst1;
    logic [0:0] ch_rstn1;
    logic       done1;

    int n_vec  = 0;
    int n_miss = 0;
    int thermo_viol = 0;
    int cnt_max = 0;
    int hold_bad = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .ext_rstn(ext_rstn),
        .sw_rst  (sw_rst),
        .ch_rstn (ch_rstn),
        .done    (done)
    );

    reset_sequencer #(
        .NUM_CH     (1),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(1),
        .STEP_CYCLES(1)
    ) dut1 (
        .clk     (clk),
        .rst     (rst1),
        .ext_rstn(ext_rstn1),
        .sw_rst  (sw_rst1),
        .ch_rstn (ch_rstn1),
        .done    (done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic sample_hold();
        if (int'(dut.r_cnt) > cnt_max) cnt_max = int'(dut.r_cnt);
        if (ch_rstn != 3'b000) hold_bad++;
    endtask

    // Thermometer shape and done consistency, watched every cycle.
    always @(negedge clk) begin
        logic [3:0] v;
        v = {1'b0, ch_rstn};
        if ((v & (v + 4'd1)) != 4'd0) thermo_viol++;
        if (done && ch_rstn != 3'b111) thermo_viol++;
        if (done1 && ch_rstn1 != 1'b1) thermo_viol++;
    end

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        ext_rstn = 1'b0; ext_rstn1 = 1'b0;
        sw_rst = 1'b0; sw_rst1 = 1'b0;
        steps(3);
        check("rst_ch", ch_rstn, 3'b000);
        check("rst_done", done, 1'b0);
        check("rst_ch1", ch_rstn1, 1'b0);

        rst = 1'b0; rst1 = 1'b0;
        ext_rstn = 1'b1; ext_rstn1 = 1'b1;
        step();
        check("e1_ch1", ch_rstn1, 1'b0);
        step();
        check("e2_ch1", ch_rstn1, 1'b0);
        check("e2_done1", done1, 1'b0);
        step();
        check("e3_ch1", ch_rstn1, 1'b1);
        check("e3_done1", done1, 1'b1);
        steps(14);
        check("e17_ch", ch_rstn, 3'b000);
        step();
        check("e18_ch", ch_rstn, 3'b001);
        steps(7);
        check("e25_ch", ch_rstn, 3'b001);
        step();
        check("e26_ch", ch_rstn, 3'b011);
        steps(7);
        check("e33_ch", ch_rstn, 3'b011);
        check("e33_done", done, 1'b0);
        step();
        check("e34_ch", ch_rstn, 3'b111);
        check("e34_done", done, 1'b1);
        steps(20);
        check("run_ch", ch_rstn, 3'b111);
        check("run_done", done, 1'b1);

        // one-cycle ext_rstn low pulse in RUN
        ext_rstn = 1'b0;
        step();
        ext_rstn = 1'b1;
        check("pulse_e0", ch_rstn, 3'b111);
        step();
        check("pulse_e1", ch_rstn, 3'b111);
        step();
        check("pulse_e2_ch", ch_rstn, 3'b000);
        check("pulse_e2_done", done, 1'b0);
        steps(15);
        check("pulse_e17", ch_rstn, 3'b000);
        step();
        check("pulse_e18", ch_rstn, 3'b001);
        steps(8);
        check("pulse_e26", ch_rstn, 3'b011);
        steps(3);

        // sw_rst while in STEP with 011
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        check("sw_e0_ch", ch_rstn, 3'b000);
        check("sw_e0_done", done, 1'b0);
        steps(15);
        check("sw_e15", ch_rstn, 3'b000);
        step();
        check("sw_e16", ch_rstn, 3'b001);
        steps(8);
        check("sw_e24", ch_rstn, 3'b011);
        steps(7);
        check("sw_e31_done", done, 1'b0);
        step();
        check("sw_e32_ch", ch_rstn, 3'b111);
        check("sw_e32_done", done, 1'b1);

        // periodic sw_rst pulses keep HOLD from completing
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        check("hold_enter", ch_rstn, 3'b000);
        for (int i = 0; i < 6; i++) begin
            sw_rst = 1'b1;
            step();
            sample_hold();
            sw_rst = 1'b0;
            for (int j = 0; j < 9; j++) begin
                step();
                sample_hold();
            end
        end
        check("hold_ch", hold_bad, 0);
        check("hold_cnt_max", cnt_max, 9);
        steps(6);
        check("hold_tail_ch", ch_rstn, 3'b000);
        step();
        check("hold_rel_ch", ch_rstn, 3'b001);

        // rst mid-STEP
        steps(3);
        rst = 1'b1;
        step();
        check("rst_mid_ch", ch_rstn, 3'b000);
        check("rst_mid_done", done, 1'b0);
        rst = 1'b0;
        steps(17);
        check("rst_e17", ch_rstn, 3'b000);
        step();
        check("rst_e18", ch_rstn, 3'b001);
        steps(16);
        check("rst_e34_ch", ch_rstn, 3'b111);
        check("rst_e34_done", done, 1'b1);

        check("ch1_run", ch_rstn1, 1'b1);
        check("done1_run", done1, 1'b1);
        check("thermo", thermo_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
